// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, key-word layout and frame states for the PS/2 receiver
package ps2_pkg;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;

  localparam int KEY_TOG = 10;
  localparam int KEY_PRS = 9;
  localparam int KEY_EXT = 8;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  // Keyboard status/ack bytes that never map to a key.
  function automatic logic is_discard(input logic [7:0] code);
    return (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
           (code == 8'hFA) || (code == 8'hFC) || (code == 8'hFE) ||
           (code == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus FILTER-sample glitch filter for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line,
  output logic level
);

  localparam int CW = $clog2(FILTER + 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Lines idle high, so the filtered level resets to 1.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      if (sync_q != level_q) begin
        if (cnt_q == CW'(FILTER - 1)) begin
          level_q <= sync_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 frame receiver folding E0/F0/E1 prefixes into ps2_key events
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic clk_f;
  logic data_f;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line    (ps2_clk),
    .level   (clk_f)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line    (ps2_data),
    .level   (data_f)
  );

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0]   key_q, key_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic          clk_prev_q;

  logic fall_w;
  logic edge_w;
  logic byte_ok_w;

  assign fall_w    = clk_prev_q & ~clk_f;
  assign edge_w    = clk_prev_q ^ clk_f;
  assign byte_ok_w = data_f & (^{shift_q, parity_q});

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      tmo_q      <= '0;
      key_q      <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      key_q      <= key_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      clk_prev_q <= clk_f;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    skip_d    = skip_q;
    key_d     = key_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (edge_w || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);

    // A clock edge restarts the watchdog, so it only fires on a stalled line.
    if (state_q != ST_IDLE && !edge_w && tmo_q == TW'(TIMEOUT)) begin
      err_d     = 1'b1;
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
      tmo_d     = '0;
    end else if (fall_w) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_f) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_f;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!byte_ok_w) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (skip_q != '0) begin
            skip_d = skip_q - 3'd1;
          end else if (shift_q == CODE_E0) begin
            ext_d = 1'b1;
          end else if (shift_q == CODE_F0) begin
            brk_d = 1'b1;
          end else if (shift_q == CODE_E1) begin
            skip_d = PAUSE_SKIP;
          end else if (is_discard(shift_q)) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            key_d          = {~key_q[KEY_TOG], 2'b00, shift_q};
            key_d[KEY_PRS] = ~brk_q;
            key_d[KEY_EXT] = ext_q;
            stb_d          = 1'b1;
            ext_d          = 1'b0;
            brk_d          = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ps2_key = key_q;
  assign key_stb = stb_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - randomized self-checking bench for ps2_key_rx against a byte-level model
module tb_ps2_key_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_stb;
  logic        err;

  int errors = 0;
  int checks = 0;

  int stb_cnt = 0;
  int err_cnt = 0;
  int spurious = 0;
  int wide_stb = 0;
  logic [10:0] prev_key = '0;
  logic        prev_stb = 1'b0;

  // Behavioural model state
  logic [10:0] m_key;
  logic        m_ext;
  logic        m_brk;
  int          m_skip;
  int          m_stb;
  int          m_err;

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .key_stb  (key_stb),
    .err      (err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (key_stb) stb_cnt++;
      if (err) err_cnt++;
      if (ps2_key !== prev_key && !key_stb) spurious++;
      if (key_stb && prev_stb) wide_stb++;
    end
    prev_key = ps2_key;
    prev_stb = key_stb;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad);
    send_bit(1'b1);
    ps2_data = 1'b1;
    idle(40);
  endtask

  task automatic model_reset();
    m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic bad);
    m_stb = 0;
    m_err = 0;
    if (bad) begin
      m_err = 1; m_ext = 0; m_brk = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_stb = 1; m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(5);
    @(negedge clk_sys);
    checks++;
    if (ps2_key !== 11'h000 || key_stb !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got key=%h stb=%b err=%b want 000/0/0", ps2_key, key_stb, err);
    end
    reset_n = 1'b1;
    model_reset();
    idle(20);
  endtask

  task automatic test_make();
    int s0 = stb_cnt;
    model_byte(8'h29, 0);
    send_frame(8'h29, 0);
    checks++;
    if (stb_cnt - s0 !== 1 || ps2_key !== 11'h629) begin
      errors++;
      $display("FAIL make_29: got stb=%0d key=%h want 1/629", stb_cnt - s0, ps2_key);
    end
  endtask

  task automatic test_ext_break();
    logic [7:0] seq [3] = '{8'hE0, 8'hF0, 8'h75};
    int s0 = stb_cnt;
    for (int i = 0; i < 3; i++) begin
      model_byte(seq[i], 0);
      send_frame(seq[i], 0);
      if (i < 2) begin
        checks++;
        if (stb_cnt - s0 !== 0) begin
          errors++;
          $display("FAIL ext_break_prefix%0d: got stb=%0d want 0", i, stb_cnt - s0);
        end
      end
    end
    checks++;
    if (stb_cnt - s0 !== 1 || ps2_key !== 11'h175 || ps2_key !== m_key) begin
      errors++;
      $display("FAIL ext_break_75: got stb=%0d key=%h want 1/175", stb_cnt - s0, ps2_key);
    end
  endtask

  task automatic test_parity();
    int s0 = stb_cnt;
    int e0 = err_cnt;
    model_byte(8'hF0, 0);
    send_frame(8'hF0, 0);
    model_byte(8'h1C, 1);
    send_frame(8'h1C, 1);
    checks++;
    if (err_cnt - e0 !== 1 || stb_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL parity_err: got err=%0d stb=%0d want 1/0", err_cnt - e0, stb_cnt - s0);
    end
    model_byte(8'h1C, 0);
    send_frame(8'h1C, 0);
    checks++;
    if (ps2_key[9:0] !== 10'h21C || ps2_key !== m_key || stb_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL parity_recover: got key=%h stb=%0d want %h/1", ps2_key, stb_cnt - s0, m_key);
    end
  endtask

  task automatic test_timeout();
    int s0 = stb_cnt;
    int e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    idle(TIMEOUT + 10);
    idle(40);
    m_ext = 0; m_brk = 0;
    checks++;
    if (err_cnt - e0 !== 1 || stb_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL timeout_err: got err=%0d stb=%0d want 1/0", err_cnt - e0, stb_cnt - s0);
    end
    model_byte(8'h16, 0);
    send_frame(8'h16, 0);
    checks++;
    if (ps2_key[9:0] !== 10'h216 || ps2_key !== m_key || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL timeout_recover: got key=%h err=%0d want %h/1", ps2_key, err_cnt - e0, m_key);
    end
  endtask

  task automatic test_glitch();
    int s0 = stb_cnt;
    int e0 = err_cnt;
    logic [10:0] k0 = ps2_key;
    ps2_clk = 1'b0;
    idle(FILTER - 2);
    ps2_clk = 1'b1;
    idle(40);
    checks++;
    if (err_cnt - e0 !== 0 || stb_cnt - s0 !== 0 || ps2_key !== k0) begin
      errors++;
      $display("FAIL glitch: got err=%0d stb=%0d key=%h want 0/0/%h", err_cnt - e0, stb_cnt - s0, ps2_key, k0);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h05};
    int s0 = stb_cnt;
    for (int i = 0; i < 9; i++) begin
      model_byte(seq[i], 0);
      send_frame(seq[i], 0);
    end
    checks++;
    if (stb_cnt - s0 !== 1 || ps2_key[9:0] !== 10'h205 || ps2_key !== m_key) begin
      errors++;
      $display("FAIL pause_seq: got stb=%0d key=%h want 1/%h", stb_cnt - s0, ps2_key, m_key);
    end
  endtask

  task automatic test_random();
    logic [7:0] disc [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    for (int n = 0; n < 30; n++) begin
      int s0 = stb_cnt;
      int e0 = err_cnt;
      logic [7:0] b;
      logic bad;
      int r = $urandom_range(0, 9);
      bad = ($urandom_range(0, 9) == 0);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = disc[$urandom_range(0, 6)];
      else if (r == 3 && $urandom_range(0, 3) == 0) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      model_byte(b, bad);
      send_frame(b, bad);
      checks++;
      if (stb_cnt - s0 !== m_stb || err_cnt - e0 !== m_err || ps2_key !== m_key) begin
        errors++;
        $display("FAIL random_%0d byte=%h bad=%0d: got stb=%0d err=%0d key=%h want %0d/%0d/%h",
                 n, b, bad, stb_cnt - s0, err_cnt - e0, ps2_key, m_stb, m_err, m_key);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int s0;
    int e0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset_n = 1'b0;
    idle(5);
    @(negedge clk_sys);
    checks++;
    if (ps2_key !== 11'h000) begin
      errors++;
      $display("FAIL reset_midframe_key: got %h want 000", ps2_key);
    end
    @(posedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    idle(20);
    s0 = stb_cnt;
    e0 = err_cnt;
    model_byte(8'h6B, 0);
    send_frame(8'h6B, 0);
    checks++;
    if (ps2_key !== 11'h66B || ps2_key !== m_key || stb_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL reset_midframe_6B: got key=%h stb=%0d err=%0d want 66B/1/0",
               ps2_key, stb_cnt - s0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity();
    test_timeout();
    test_glitch();
    test_pause();
    test_random();
    test_reset_midframe();
    checks++;
    if (spurious !== 0 || wide_stb !== 0) begin
      errors++;
      $display("FAIL stb_integrity: got spurious=%0d wide=%0d want 0/0", spurious, wide_stb);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Receives the raw PS/2 keyboard line pair, deserialises 11-bit device-to-host frames and folds Set-2 prefix bytes (E0, F0) into single key events. Each event is published in the 11-bit `ps2_key` format already consumed by the arcade cores' input decoders: bit 10 toggles per event, bit 9 is pressed, bit 8 is extended and [7:0] is the scancode. It sits between the board PS/2 pins and the core's keyboard `casex` decoder, replacing the HPS-supplied key word when a physical keyboard is attached.

## Interface
Parameters:
- FILTER, 8, consecutive equal samples required before a filtered line level changes
- TIMEOUT, 100000, `clk_sys` cycles without a clock edge mid-frame before the frame is aborted

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge
- reset_n  in  1  synchronous reset, active-low
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- ps2_key  out  11  {toggle, pressed, extended, code[7:0]}
- key_stb  out  1  one-cycle pulse when `ps2_key` updates
- err  out  1  one-cycle pulse on parity, start, stop or timeout error

## Operation
- Both lines pass through a 2-FF synchroniser and then a FILTER-sample glitch filter. The filtered level changes only after FILTER consecutive equal synchronised samples.
- A falling edge of filtered clock is a sample point. Data is read from filtered data on the same cycle.
- Frame FSM states:
  - IDLE: wait for an edge. Data 0 goes to DATA with bit count 0; data 1 pulses `err` and stays in IDLE.
  - DATA: shift in 8 bits LSB-first, then go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: the byte is valid only if the stop bit is 1 and data^parity has odd weight. Otherwise pulse `err`, clear the prefix flags and return to IDLE.
- Byte handling, in priority order:
  - E0: set `ext_f`.
  - F0: set `brk_f`.
  - E1: set skip count to 7. While skip is nonzero, each valid byte decrements it and is discarded, with no event.
  - 00, AA, EE, FA, FC, FE, FF: discarded and flags cleared.
  - Any other byte: emit an event with `ps2_key <= {~ps2_key[10], ~brk_f, ext_f, byte}`, pulse `key_stb`, then clear both flags.
- Timeout: a counter resets on every filtered-clock edge. In any state other than IDLE, reaching TIMEOUT pulses `err`, returns to IDLE and clears the flags and bit count. The counter width is clog2(TIMEOUT+1).
- Reset values:
  - Outputs: `ps2_key` = 0, `key_stb` = 0, `err` = 0.
  - Internal: FSM in IDLE, flags and skip count cleared.
  - Filters: filtered levels 1, filter counters cleared.
- Reset asserted mid-frame discards the partial frame. The first frame after release must start with a fresh start bit.
- A valid byte and a timeout cannot coincide, because the counter resets on that edge. If an error and a prefix fall on the same byte, the error wins.

## Timing
- Synchroniser plus filter latency: 2+FILTER cycles from pin change to filtered change.
- `ps2_key` and `key_stb` update on the cycle after the stop-bit sample edge. `key_stb` is high for exactly that one cycle.
- `err` is a single-cycle pulse, registered, on the cycle after detection.
- No back-pressure. Events are at most one per frame (≥ ~1 ms apart at 10–16.7 kHz), so no buffering is needed.
- `ps2_key` holds its value between events. Downstream detects events by bit-10 change, as the cores already do.

## Structure
- Package `ps2_pkg` holds:
  - Prefix constants E0, F0 and E1.
  - The discard-code list.
  - The `ps2_key` field bit positions (TOG=10, PRS=9, EXT=8).
  - The frame-state enum IDLE/DATA/PARITY/STOP.
- Sub-module `ps2_line_filter` (synchroniser plus FILTER counter, one bit) is instantiated twice, once for clock and once for data.
- The frame FSM, byte classifier and timeout counter live in `ps2_key_rx`.

## Test plan
- Make code: frame 0x29 with correct parity from reset → one `key_stb`, `ps2_key` = 11'h629 (toggle 1, pressed 1, ext 0).
- Extended break: frames E0, F0, 75 → exactly one `key_stb` after the third frame, `ps2_key[9:0]` = 10'h175 (pressed 0, ext 1), toggle inverted.
- Parity error: frame 0x1C with a bad parity bit → `err` pulse, no `key_stb`. Then a valid 0x1C gives `ps2_key[9:0]` = 10'h21C. A preceding F0 must have been cleared.
- Timeout: 5 bits of a frame, then clock idle for TIMEOUT+10 cycles → one `err` pulse. The next full frame 0x16 is received correctly as 10'h216.
- Glitch and reset: a clock low pulse of FILTER−2 cycles produces no sample. Asserting `reset_n` = 0 after 4 bits, then a full 0x6B frame → `ps2_key` = 11'h66B, with toggle starting from 0.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 0x05 → only 0x05 emits an event, `ps2_key[9:0]` = 10'h205.
